// File: rtl/pe_row_pkg.sv
// Shared definitions for the PE row sequencer: default datapath width and
// the sequencer state encoding.
package pe_row_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      FLUSH = 3'd3,
      DRAIN = 3'd4,
      OUT   = 3'd5
   } state_e;

endpackage

// File: rtl/pe_row_res_buf.sv
// N-entry result capture buffer for the PE row sequencer.
// Optional build macro PE_ROW_SEQ_RELU_EN: when defined, each captured sample
// is treated as signed and negative values are stored as zero.
module pe_row_res_buf
   import pe_row_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = pe_row_pkg::DATA_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [$clog2(N)-1:0] wr_slot,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [$clog2(N)-1:0] rd_idx,
   output logic [DATA_W-1:0]    rd_data
);

   logic [DATA_W-1:0] slot_q [N];
   logic [DATA_W-1:0] slot_d [N];
   logic [DATA_W-1:0] cap_val;

   // Write-path value, optionally clamped at zero for negative samples.
   always_comb begin
      cap_val = wr_data;
`ifdef PE_ROW_SEQ_RELU_EN
      if (wr_data[DATA_W-1]) begin
         cap_val = {DATA_W{1'b0}};
      end else begin
         cap_val = wr_data;
      end
`endif
   end

   // Next contents: only the addressed slot changes on a capture.
   always_comb begin
      slot_d = slot_q;
      if (wr_en) begin
         slot_d[wr_slot] = cap_val;
      end else begin
         slot_d = slot_q;
      end
   end

   // Slot storage; cleared on reset so an abandoned job leaves nothing visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            slot_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         slot_q <= slot_d;
      end
   end

   assign rd_data = slot_q[rd_idx];

endmodule

// File: rtl/pe_row_seq.sv
// Sequencer at the left end of one systolic PE row: clears the row, streams
// K operands into PE[0], flushes the skew, reads the N results back out of
// PE[0] and presents them on a valid/ready stream.
// Optional build macro PE_ROW_SEQ_RELU_EN enables a ReLU clamp on capture
// (implemented in pe_row_res_buf).
module pe_row_seq
   import pe_row_pkg::*;
#(
   parameter int N      = 4,
   parameter int K      = 8,
   parameter int DATA_W = pe_row_pkg::DATA_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [DATA_W-1:0]    op_data,
   output logic                 arr_clr,
   output logic                 arr_read,
   output logic [DATA_W-1:0]    arr_l_d_i,
   input  logic [DATA_W-1:0]    arr_l_d_o,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [DATA_W-1:0]    res_data,
   output logic [$clog2(N)-1:0] res_idx
);

   localparam int IDX_W = $clog2(N);
   localparam int CYC_W = $clog2(2 * N);
   localparam int OPC_W = (K > 1) ? $clog2(K) : 1;

   state_e             state_q, state_d;
   logic [OPC_W-1:0]   op_cnt_q, op_cnt_d;
   logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]  l_d_i_q, l_d_i_d;
   logic               clr_q, clr_d;
   logic               read_q, read_d;
   logic               done_q, done_d;
   logic               cap_en;
   logic [IDX_W-1:0]   cap_slot;
   logic [DATA_W-1:0]  buf_rd_data;

   // Next-state, counters and registered row controls.
   always_comb begin
      state_d   = state_q;
      op_cnt_d  = op_cnt_q;
      cyc_cnt_d = cyc_cnt_q;
      idx_d     = idx_q;
      l_d_i_d   = {DATA_W{1'b0}};
      clr_d     = 1'b0;
      read_d    = 1'b0;
      done_d    = 1'b0;
      cap_en    = 1'b0;
      // Odd drain cycles carry PE results; slot is dc >> 1.
      cap_slot  = cyc_cnt_q[CYC_W-1:1];

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLEAR;
               clr_d   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            state_d  = FEED;
            op_cnt_d = {OPC_W{1'b0}};
         end
         FEED: begin
            // op_ready is high throughout FEED, so op_valid is the handshake.
            if (op_valid) begin
               l_d_i_d = op_data;
               if (op_cnt_q == OPC_W'(K - 1)) begin
                  state_d   = FLUSH;
                  op_cnt_d  = {OPC_W{1'b0}};
                  cyc_cnt_d = {CYC_W{1'b0}};
               end else begin
                  op_cnt_d = op_cnt_q + OPC_W'(1);
               end
            end else begin
               l_d_i_d = {DATA_W{1'b0}};
            end
         end
         FLUSH: begin
            if (cyc_cnt_q == CYC_W'(N - 2)) begin
               state_d   = DRAIN;
               cyc_cnt_d = {CYC_W{1'b0}};
               read_d    = 1'b1;
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
            end
         end
         DRAIN: begin
            cap_en = cyc_cnt_q[0];
            if (cyc_cnt_q == CYC_W'(2 * N - 1)) begin
               state_d   = OUT;
               cyc_cnt_d = {CYC_W{1'b0}};
               idx_d     = {IDX_W{1'b0}};
            end else begin
               cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
               read_d    = 1'b1;
            end
         end
         OUT: begin
            if (res_ready) begin
               if (idx_q == IDX_W'(N - 1)) begin
                  state_d = IDLE;
                  idx_d   = {IDX_W{1'b0}};
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         op_cnt_q  <= {OPC_W{1'b0}};
         cyc_cnt_q <= {CYC_W{1'b0}};
         idx_q     <= {IDX_W{1'b0}};
         l_d_i_q   <= {DATA_W{1'b0}};
         clr_q     <= 1'b0;
         read_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_cnt_q  <= op_cnt_d;
         cyc_cnt_q <= cyc_cnt_d;
         idx_q     <= idx_d;
         l_d_i_q   <= l_d_i_d;
         clr_q     <= clr_d;
         read_q    <= read_d;
         done_q    <= done_d;
      end
   end

   pe_row_res_buf #(
      .N      (N),
      .DATA_W (DATA_W)
   ) u_res_buf (
      .clk     (clk),
      .rst     (reset),
      .wr_en   (cap_en),
      .wr_slot (cap_slot),
      .wr_data (arr_l_d_o),
      .rd_idx  (idx_q),
      .rd_data (buf_rd_data)
   );

   assign busy      = (state_q != IDLE);
   assign op_ready  = (state_q == FEED);
   assign res_valid = (state_q == OUT);
   assign res_idx   = idx_q;
   assign res_data  = res_valid ? buf_rd_data : {DATA_W{1'b0}};
   assign done      = done_q;
   assign arr_clr   = clr_q;
   assign arr_read  = read_q;
   assign arr_l_d_i = l_d_i_q;

endmodule

// File: tb/tb_pe_row_seq.sv
// Directed bench for pe_row_seq with a behavioural PE row model.
module tb_pe_row_seq;

   localparam int N = 4;
   localparam int K = 8;
   localparam int W = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  op_data;
   logic          arr_clr;
   logic          arr_read;
   logic [W-1:0]  arr_l_d_i;
   logic [W-1:0]  arr_l_d_o;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic [1:0]    res_idx;

   int n_checks = 0;
   int n_bad    = 0;

   always #5 clk = ~clk;

   pe_row_seq #(.N(N), .K(K), .DATA_W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_data   (op_data),
      .arr_clr   (arr_clr),
      .arr_read  (arr_read),
      .arr_l_d_i (arr_l_d_i),
      .arr_l_d_o (arr_l_d_o),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_idx   (res_idx)
   );

   // ---------------- PE row model ----------------
   // Operands ripple right one PE per cycle; each PE accumulates x*w.
   // In read mode PE[0] presents the PE results one after another with a
   // bubble between them: PE[j] appears on l_d_o in read cycle 2j+1.
   logic [W-1:0] w    [N];
   logic [W-1:0] acc  [N];
   logic [W-1:0] pass [N];
   logic [W-1:0] out_r = '0;
   int           rc = 0;

   assign arr_l_d_o = out_r;

   always @(posedge clk) begin
      if (arr_clr) begin
         for (int j = 0; j < N; j++) begin
            acc[j]  <= '0;
            pass[j] <= '0;
         end
      end else begin
         acc[0]  <= acc[0] + arr_l_d_i * w[0];
         pass[0] <= arr_l_d_i;
         for (int j = 1; j < N; j++) begin
            acc[j]  <= acc[j] + pass[j-1] * w[j];
            pass[j] <= pass[j-1];
         end
      end
      if (arr_read) begin
         out_r <= (rc % 2 == 0) ? acc[(rc / 2) % N] : '0;
         rc    <= rc + 1;
      end else begin
         out_r <= '0;
         rc    <= 0;
      end
   end

   // ---------------- job driver (records observations only) ----------------
   logic [W-1:0] ops     [8];
   logic [W-1:0] got     [8];
   logic [1:0]   gidx    [8];
   logic [W-1:0] stall_d [8];
   logic [1:0]   stall_i [8];
   int nres, feed_cyc, done_cyc, clr_cnt, clr_first, busy_gap, n_stall;
   logic done_after;

   task automatic do_job(input int stall_len, input logic [15:0] bub);
      int oi;
      int fc;
      bit fin;
      oi = 0; fc = 0; fin = 0;
      nres = 0; feed_cyc = 0; done_cyc = -1; clr_cnt = 0; clr_first = -1;
      busy_gap = 0; n_stall = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 300 && !fin; c++) begin
         if (arr_clr) begin
            clr_cnt++;
            if (clr_first < 0) clr_first = c;
         end
         if (op_ready) begin
            feed_cyc++;
            if ((fc < 16 && bub[fc]) || oi >= K) begin
               op_valid = 1'b0;
            end else begin
               op_valid = 1'b1;
               op_data  = ops[oi];
               oi++;
            end
            fc++;
         end else begin
            op_valid = 1'b0;
            op_data  = '0;
         end
         if (res_valid) begin
            if (res_idx == 2'd1 && n_stall < stall_len) begin
               res_ready = 1'b0;
               stall_d[n_stall] = res_data;
               stall_i[n_stall] = res_idx;
               n_stall++;
            end else begin
               res_ready = 1'b1;
               if (nres < 8) begin
                  got[nres]  = res_data;
                  gidx[nres] = res_idx;
               end
               nres++;
            end
         end else begin
            res_ready = 1'b1;
         end
         if (done) begin
            done_cyc = c;
            fin = 1;
         end
         if (!busy && !fin) busy_gap++;
         @(negedge clk);
      end
      done_after = done;
      op_valid  = 1'b0;
      res_ready = 1'b1;
   endtask

   task automatic load_ramp();
      for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      if ({busy, done, op_ready, arr_clr, arr_read, res_valid} !== 6'b0) begin
         $display("FAIL reset_ctrl: got %b want 000000", {busy, done, op_ready, arr_clr, arr_read, res_valid});
         n_bad++;
      end
      n_checks++;
      if ({arr_l_d_i, res_data, res_idx} !== 34'd0) begin
         $display("FAIL reset_data: got %h want 0", {arr_l_d_i, res_data, res_idx});
         n_bad++;
      end
      n_checks++;
   endtask

   task automatic test_basic();
      w[0] = 16'd1; w[1] = 16'd2; w[2] = 16'd3; w[3] = 16'd4;
      load_ramp();
      do_job(0, 16'h0000);
      if (nres !== 4) begin $display("FAIL basic_nres: got %0d want 4", nres); n_bad++; end
      n_checks++;
      for (int i = 0; i < 4; i++) begin
         if (got[i] !== 16'(36 * (i + 1)) || gidx[i] !== 2'(i)) begin
            $display("FAIL basic_res%0d: got %0d@%0d want %0d@%0d", i, got[i], gidx[i], 36 * (i + 1), i);
            n_bad++;
         end
         n_checks++;
      end
      if (done_cyc - clr_first !== 1 + 8 + 3 + 8 + 4) begin
         $display("FAIL basic_latency: got %0d want 24", done_cyc - clr_first);
         n_bad++;
      end
      n_checks++;
      if (clr_cnt !== 1 || clr_first !== 1) begin
         $display("FAIL basic_clr: got cnt=%0d first=%0d want 1/1", clr_cnt, clr_first);
         n_bad++;
      end
      n_checks++;
      if (feed_cyc !== 8) begin $display("FAIL basic_feed: got %0d want 8", feed_cyc); n_bad++; end
      n_checks++;
      if (busy_gap !== 0) begin $display("FAIL basic_busy: got %0d idle cycles want 0", busy_gap); n_bad++; end
      n_checks++;
      if (done_after !== 1'b0) begin $display("FAIL basic_done_pulse: got %b want 0", done_after); n_bad++; end
      n_checks++;
   endtask

   task automatic test_bubbles();
      w[0] = 16'd1; w[1] = 16'd2; w[2] = 16'd3; w[3] = 16'd4;
      load_ramp();
      do_job(0, 16'b0000_0000_0011_0100);
      if (feed_cyc !== 11) begin $display("FAIL bubble_feed: got %0d want 11", feed_cyc); n_bad++; end
      n_checks++;
      if (done_cyc - clr_first !== 27) begin
         $display("FAIL bubble_latency: got %0d want 27", done_cyc - clr_first);
         n_bad++;
      end
      n_checks++;
      for (int i = 0; i < 4; i++) begin
         if (got[i] !== 16'(36 * (i + 1))) begin
            $display("FAIL bubble_res%0d: got %0d want %0d", i, got[i], 36 * (i + 1));
            n_bad++;
         end
         n_checks++;
      end
   endtask

   task automatic test_backpressure();
      w[0] = 16'd1; w[1] = 16'd2; w[2] = 16'd3; w[3] = 16'd4;
      load_ramp();
      do_job(5, 16'h0000);
      if (n_stall !== 5) begin $display("FAIL bp_stall_len: got %0d want 5", n_stall); n_bad++; end
      n_checks++;
      for (int i = 0; i < 5; i++) begin
         if (stall_d[i] !== 16'd72 || stall_i[i] !== 2'd1) begin
            $display("FAIL bp_hold%0d: got %0d@%0d want 72@1", i, stall_d[i], stall_i[i]);
            n_bad++;
         end
         n_checks++;
      end
      if (nres !== 4) begin $display("FAIL bp_nres: got %0d want 4", nres); n_bad++; end
      n_checks++;
      for (int i = 0; i < 4; i++) begin
         if (got[i] !== 16'(36 * (i + 1)) || gidx[i] !== 2'(i)) begin
            $display("FAIL bp_res%0d: got %0d@%0d want %0d@%0d", i, got[i], gidx[i], 36 * (i + 1), i);
            n_bad++;
         end
         n_checks++;
      end
   endtask

   task automatic test_wrap();
      w[0] = 16'd1; w[1] = 16'd1; w[2] = 16'd1; w[3] = 16'd1;
      for (int i = 0; i < 8; i++) ops[i] = (i < 4) ? 16'h4000 : 16'h0000;
      do_job(0, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (got[i] !== 16'h0000) begin
            $display("FAIL wrap_res%0d: got %h want 0000", i, got[i]);
            n_bad++;
         end
         n_checks++;
      end
   endtask

   task automatic test_reset_mid_drain();
      int oi;
      oi = 0;
      w[0] = 16'd1; w[1] = 16'd2; w[2] = 16'd3; w[3] = 16'd4;
      load_ramp();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 100 && !arr_read; c++) begin
         if (op_ready && oi < K) begin
            op_valid = 1'b1;
            op_data  = ops[oi];
            oi++;
         end else begin
            op_valid = 1'b0;
         end
         @(negedge clk);
      end
      op_valid = 1'b0;
      if (arr_read !== 1'b1) begin
         $display("FAIL rst_drain_reach: got read=%b want 1", arr_read);
         n_bad++;
      end
      n_checks++;
      repeat (3) @(negedge clk);
      if (arr_read !== 1'b1) begin
         $display("FAIL rst_drain_dc3: got read=%b want 1", arr_read);
         n_bad++;
      end
      n_checks++;
      reset = 1'b1;
      #1;
      if ({busy, done, op_ready, arr_clr, arr_read, res_valid, arr_l_d_i, res_data, res_idx} !== 40'd0) begin
         $display("FAIL rst_drain_outs: got %h want 0",
                  {busy, done, op_ready, arr_clr, arr_read, res_valid, arr_l_d_i, res_data, res_idx});
         n_bad++;
      end
      n_checks++;
      @(negedge clk);
      reset = 1'b0;
      do_job(0, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (got[i] !== 16'(36 * (i + 1))) begin
            $display("FAIL rst_rerun_res%0d: got %0d want %0d", i, got[i], 36 * (i + 1));
            n_bad++;
         end
         n_checks++;
      end
   endtask

   task automatic test_relu();
      logic [W-1:0] exp0;
`ifdef PE_ROW_SEQ_RELU_EN
      exp0 = 16'h0000;
`else
      exp0 = 16'hFFDC;
`endif
      w[0] = 16'hFFFF; w[1] = 16'd2; w[2] = 16'd3; w[3] = 16'd4;
      load_ramp();
      do_job(0, 16'h0000);
      if (got[0] !== exp0) begin $display("FAIL relu_res0: got %h want %h", got[0], exp0); n_bad++; end
      n_checks++;
      if (got[3] !== 16'd144) begin $display("FAIL relu_res3: got %0d want 144", got[3]); n_bad++; end
      n_checks++;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      op_valid  = 1'b0;
      op_data   = '0;
      res_ready = 1'b1;
      #1;
      test_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_basic();
      test_bubbles();
      test_backpressure();
      test_wrap();
      test_reset_mid_drain();
      test_relu();
      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
